// File: rtl/irig_pkg.sv
// Shared IRIG-B constants: nominal pulse widths, classifier thresholds in tenths of a
// millisecond, decoder FSM states and the symbol codes used by the framing FSM.
package irig_pkg;

    localparam int unsigned NOM_D0_MS   = 2;
    localparam int unsigned NOM_D1_MS   = 5;
    localparam int unsigned NOM_MARK_MS = 8;

    // Decision points sit halfway between the nominal widths.
    localparam int unsigned TENTHS_MIN = 10;
    localparam int unsigned TENTHS_01  = 35;
    localparam int unsigned TENTHS_1M  = 65;
    localparam int unsigned TENTHS_MAX = 95;
    localparam int unsigned TENTHS_LOS = 120;

    typedef enum logic [1:0] {
        ST_WAIT_LOW,
        ST_LOW,
        ST_HIGH,
        ST_OVF
    } state_e;

    typedef enum logic [1:0] {
        SYM_ERR,
        SYM_D0,
        SYM_D1,
        SYM_MARK
    } sym_e;

    typedef enum logic [1:0] {
        TS_SEL_NONE,
        TS_SEL_D0,
        TS_SEL_D1,
        TS_SEL_MARK
    } ts_select_e;

    function automatic int unsigned irig_ticks(input int unsigned tpm, input int unsigned tenths);
        return tpm * tenths / 10;
    endfunction

    function automatic sym_e irig_classify(input int unsigned w, input int unsigned tpm);
        if (w < irig_ticks(tpm, TENTHS_MIN))       return SYM_ERR;
        else if (w < irig_ticks(tpm, TENTHS_01))   return SYM_D0;
        else if (w < irig_ticks(tpm, TENTHS_1M))   return SYM_D1;
        else if (w <= irig_ticks(tpm, TENTHS_MAX)) return SYM_MARK;
        else                                       return SYM_ERR;
    endfunction

endpackage

// File: rtl/irig_sync_filter.sv
// Two-flop synchroniser followed by a stability filter; the filtered level only follows
// the input after it has differed for FILT_LEN consecutive cycles.
module irig_sync_filter #(
    parameter int unsigned FILT_LEN = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic irig_in,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic quiet_o
);

    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
                rise_d  = ~level_q;
                fall_d  = level_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= irig_in;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    // Low everywhere in the pipe, so no edge can be pending.
    assign quiet_o = ~sync1_q & ~sync2_q & ~level_q;

endmodule

// File: rtl/irig_symbol_decoder.sv
// IRIG-B front end: measures filtered high-pulse widths, classifies them as 0/1/MARK and
// flags malformed pulses and carrier loss with registered one-cycle strobes.
module irig_symbol_decoder
    import irig_pkg::*;
#(
    parameter int unsigned TICKS_PER_MS = 10000,
    parameter int unsigned FILT_LEN     = 16,
    parameter int unsigned CNT_W        = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic irig_in,
    output logic irig_rise,
    output logic irig_d0,
    output logic irig_d1,
    output logic irig_mark,
    output logic irig_err,
    output logic sig_valid
);

    localparam logic [CNT_W-1:0] T_MAX = CNT_W'(irig_ticks(TICKS_PER_MS, TENTHS_MAX));
    localparam logic [CNT_W-1:0] T_LOS = CNT_W'(irig_ticks(TICKS_PER_MS, TENTHS_LOS));

    logic filt_level, filt_rise, filt_fall, filt_quiet;

    irig_sync_filter #(
        .FILT_LEN (FILT_LEN)
    ) u_filter (
        .clk     (clk),
        .rst     (rst),
        .irig_in (irig_in),
        .level_o (filt_level),
        .rise_o  (filt_rise),
        .fall_o  (filt_fall),
        .quiet_o (filt_quiet)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] lcnt_q, lcnt_d;
    logic [CNT_W-1:0] hcnt_inc, lcnt_inc;
    logic             rise_q, rise_d;
    logic             d0_q, d0_d;
    logic             d1_q, d1_d;
    logic             mark_q, mark_d;
    logic             err_q, err_d;
    logic             valid_q, valid_d;

    assign hcnt_inc = hcnt_q + CNT_W'(1);
    assign lcnt_inc = lcnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        lcnt_d  = lcnt_q;
        rise_d  = 1'b0;
        d0_d    = 1'b0;
        d1_d    = 1'b0;
        mark_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_WAIT_LOW: begin
                // Two quiet cycles in a row: the synchroniser's reset zeros alone cannot release us.
                if (!filt_level && filt_quiet) begin
                    lcnt_d = CNT_W'(1);
                    if (lcnt_q != '0) state_d = ST_LOW;
                end else begin
                    lcnt_d = '0;
                end
            end
            ST_LOW: begin
                if (filt_rise) begin
                    rise_d  = 1'b1;
                    hcnt_d  = CNT_W'(1);
                    lcnt_d  = '0;
                    state_d = ST_HIGH;
                end else if (lcnt_q < T_LOS) begin
                    lcnt_d = lcnt_inc;
                    if (lcnt_inc == T_LOS) err_d = 1'b1;
                end
            end
            ST_HIGH: begin
                if (filt_fall) begin
                    case (irig_classify(32'(hcnt_q), TICKS_PER_MS))
                        SYM_D0:   d0_d   = 1'b1;
                        SYM_D1:   d1_d   = 1'b1;
                        SYM_MARK: mark_d = 1'b1;
                        default:  err_d  = 1'b1;
                    endcase
                    lcnt_d  = CNT_W'(1);
                    state_d = ST_LOW;
                end else if (hcnt_q >= T_MAX) begin
                    // This cycle is high cycle T_MAX+1: reject now, while the line is still high.
                    err_d   = 1'b1;
                    hcnt_d  = hcnt_inc;
                    state_d = ST_OVF;
                end else begin
                    hcnt_d = hcnt_inc;
                end
            end
            ST_OVF: begin
                if (filt_fall) begin
                    lcnt_d  = CNT_W'(1);
                    state_d = ST_LOW;
                end
            end
            default: state_d = ST_WAIT_LOW;
        endcase
        if (err_d)                      valid_d = 1'b0;
        else if (d0_d | d1_d | mark_d)  valid_d = 1'b1;
        else                            valid_d = valid_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_WAIT_LOW;
            hcnt_q  <= '0;
            lcnt_q  <= '0;
            rise_q  <= 1'b0;
            d0_q    <= 1'b0;
            d1_q    <= 1'b0;
            mark_q  <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            lcnt_q  <= lcnt_d;
            rise_q  <= rise_d;
            d0_q    <= d0_d;
            d1_q    <= d1_d;
            mark_q  <= mark_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end

    assign irig_rise = rise_q;
    assign irig_d0   = d0_q;
    assign irig_d1   = d1_q;
    assign irig_mark = mark_q;
    assign irig_err  = err_q;
    assign sig_valid = valid_q;

endmodule

// File: tb/tb_irig_symbol_decoder.sv
// Scoreboard bench for irig_symbol_decoder: stimulus pushes expected strobe events
// computed from the pulse-width rules, a negedge monitor pops and compares them.
module tb_irig_symbol_decoder;

    localparam int TPM   = 10;
    localparam int FLEN  = 2;
    localparam int W_MIN = TPM * 10 / 10;
    localparam int W_01  = TPM * 35 / 10;
    localparam int W_1M  = TPM * 65 / 10;
    localparam int W_MAX = TPM * 95 / 10;
    localparam int W_LOS = TPM * 120 / 10;

    typedef enum int {EV_RISE, EV_D0, EV_D1, EV_MARK, EV_ERR} ev_e;
    typedef struct {
        ev_e  ev;
        logic valid;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic irig_in = 1'b1;
    logic irig_rise, irig_d0, irig_d1, irig_mark, irig_err, sig_valid;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   n_rise = 0, n_d0 = 0, n_d1 = 0, n_mark = 0, n_err = 0;
    int   low_run = 0;
    logic model_valid = 1'b0;

    irig_symbol_decoder #(
        .TICKS_PER_MS (TPM),
        .FILT_LEN     (FLEN),
        .CNT_W        (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .irig_in   (irig_in),
        .irig_rise (irig_rise),
        .irig_d0   (irig_d0),
        .irig_d1   (irig_d1),
        .irig_mark (irig_mark),
        .irig_err  (irig_err),
        .sig_valid (sig_valid)
    );

    always #5 clk = ~clk;

    function automatic ev_e classify(input int w);
        if (w < W_MIN)       return EV_ERR;
        else if (w < W_01)   return EV_D0;
        else if (w < W_1M)   return EV_D1;
        else if (w <= W_MAX) return EV_MARK;
        else                 return EV_ERR;
    endfunction

    task automatic push(input ev_e ev);
        exp_t e;
        if (ev == EV_ERR) model_valid = 1'b0;
        else if (ev != EV_RISE) model_valid = 1'b1;
        e.ev = ev;
        e.valid = model_valid;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic drive(input logic lvl, input int n);
        irig_in = lvl;
        if (lvl) low_run = 0;
        else low_run += n;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int low, input int high);
        if (low_run + low >= W_LOS) push(EV_ERR);
        push(EV_RISE);
        push(classify(high));
        drive(1'b0, low);
        drive(1'b1, high);
    endtask

    task automatic drain();
        int k;
        k = 0;
        irig_in = 1'b0;
        while (exp_q.size() != 0 && k < 80) begin
            @(posedge clk);
            #1;
            k++;
            low_run++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d events still pending, required 0", exp_q.size());
            exp_q.delete();
        end
        drive(1'b0, 3);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rise"},  int'(irig_rise), 0);
        check({tag, "_d0"},    int'(irig_d0),   0);
        check({tag, "_d1"},    int'(irig_d1),   0);
        check({tag, "_mark"},  int'(irig_mark), 0);
        check({tag, "_err"},   int'(irig_err),  0);
        check({tag, "_valid"}, int'(sig_valid), 0);
    endtask

    always @(negedge clk) begin
        int   n;
        ev_e  got;
        exp_t e;
        if (!rst) begin
            n = int'(irig_rise) + int'(irig_d0) + int'(irig_d1) + int'(irig_mark) + int'(irig_err);
            if (n > 1) begin
                total++;
                bad++;
                $display("FAIL exclusive: %0d strobes in one cycle, required at most 1", n);
            end else if (n == 1) begin
                got = irig_rise ? EV_RISE : irig_d0 ? EV_D0 : irig_d1 ? EV_D1 :
                      irig_mark ? EV_MARK : EV_ERR;
                case (got)
                    EV_RISE: n_rise++;
                    EV_D0:   n_d0++;
                    EV_D1:   n_d1++;
                    EV_MARK: n_mark++;
                    default: n_err++;
                endcase
                $display("t=%0t strobe=%s sig_valid=%0b", $time, got.name(), sig_valid);
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected: got %s, required no strobe", got.name());
                end else begin
                    e = exp_q.pop_front();
                    if (e.ev != got || e.valid != sig_valid) begin
                        bad++;
                        $display("FAIL scoreboard: got %s valid=%0b, required %s valid=%0b",
                                 got.name(), sig_valid, e.ev.name(), e.valid);
                    end
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_d0, b_d1, b_mark, b_err, b_rise, hi, lo, wl[8];

        // 1: input high through reset; the first pulse is discarded
        irig_in = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        b_rise = n_rise;
        b_d0 = n_d0;
        drive(1'b1, 50);
        pulse(30, 20);
        drain();
        check("t1_rise_count", n_rise - b_rise, 1);
        check("t1_d0_count", n_d0 - b_d0, 1);
        check("t1_sig_valid", int'(sig_valid), 1);

        // 2: classifier boundaries
        wl = '{9, 10, 34, 35, 64, 65, 95, 96};
        b_err = n_err;
        b_mark = n_mark;
        foreach (wl[i]) pulse(30, wl[i]);
        drain();
        check("t2_err_count", n_err - b_err, 2);
        check("t2_mark_count", n_mark - b_mark, 2);

        // 3: full frame at 100 ticks per bit
        b_d0 = n_d0;
        b_d1 = n_d1;
        b_mark = n_mark;
        b_err = n_err;
        for (int i = 0; i < 100; i++) begin
            if (i < 2 || (i - 1) % 10 == 0) hi = 80;
            else hi = ($urandom_range(0, 1) == 1) ? 50 : 20;
            pulse((i == 0) ? 20 : 100 - hi, hi);
        end
        drain();
        check("t3_symbols", (n_d0 - b_d0) + (n_d1 - b_d1) + (n_mark - b_mark), 100);
        check("t3_marks", n_mark - b_mark, 11);
        check("t3_errs", n_err - b_err, 0);
        check("t3_sig_valid", int'(sig_valid), 1);

        // 4: carrier loss after a valid 1, then recovery
        pulse(30, 50);
        drain();
        b_err = n_err;
        pulse(130, 80);
        drain();
        check("t4_los_err_count", n_err - b_err, 1);
        check("t4_sig_valid", int'(sig_valid), 1);

        // 5: single-cycle glitches in both levels are filtered out
        b_err = n_err;
        b_d1 = n_d1;
        push(EV_RISE);
        push(EV_D1);
        drive(1'b0, 50);
        drive(1'b1, 1);
        drive(1'b0, 49);
        drive(1'b1, 20);
        drive(1'b0, 1);
        drive(1'b1, 29);
        drain();
        check("t5_d1_count", n_d1 - b_d1, 1);
        check("t5_err_count", n_err - b_err, 0);

        // random pulse trains
        for (int i = 0; i < 120; i++) begin
            lo = ($urandom_range(0, 7) == 0) ? int'($urandom_range(130, 140))
                                             : int'($urandom_range(3, 100));
            hi = int'($urandom_range(3, 105));
            pulse(lo, hi);
        end
        drain();

        // 6: reset in the middle of a high pulse
        pulse(30, 20);
        drain();
        push(EV_RISE);
        drive(1'b0, 20);
        drive(1'b1, 30);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_valid = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        b_d0 = n_d0;
        drive(1'b1, 18);
        pulse(30, 20);
        drain();
        check("t6_d0_count", n_d0 - b_d0, 1);
        check("t6_sig_valid", int'(sig_valid), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
